aes_round_core: RTL and testbench
=================================

AES_ROUND_CORE -- requirements
Module: aes_round_core

Interface
REQ-001 SHALL have no parameters; AES-256 only, 128-bit block, 14 rounds, fixed.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  plaintext/key request valid.
REQ-005 SHALL have port: in_ready  output  1  core can accept a request.
REQ-006 SHALL have port: plaintext_in  input  128  block, byte 0 in bits [127:120].
REQ-007 SHALL have port: key_in  input  256  cipher key, byte 0 in bits [255:248].
REQ-008 SHALL have port: key_out  output  256  registered key driven to the key expansion key input.
REQ-009 SHALL have port: round_num  output  4  round index to the key expansion.
REQ-010 SHALL have port: enable_round  output  1  key expansion advance strobe.
REQ-011 SHALL have port: round_key_in  input  128  round key for current round_num, combinational from the key expansion.
REQ-012 SHALL have port: out_valid  output  1  ciphertext valid.
REQ-013 SHALL have port: out_ready  input  1  consumer accepts ciphertext.
REQ-014 SHALL have port: ciphertext_out  output  128  result, same byte order as plaintext_in.

Function
REQ-015 SHALL implement FSM states IDLE, ROUND, DONE.
REQ-016 IDLE: in_ready=1; in_valid=1 -> latch plaintext_in into state_reg, key_in into key_out, round counter <= 0, go ROUND.
REQ-017 ROUND: round_num = counter; enable_round=1 for counter 0..13, 0 for counter 14.
REQ-018 Counter 0: state_reg <= state_reg XOR round_key_in (initial AddRoundKey).
REQ-019 Counter 1..13: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) XOR round_key_in.
REQ-020 Counter 14: state_reg <= ShiftRows(SubBytes(state_reg)) XOR round_key_in; go DONE.
REQ-021 Counter SHALL increment by 1 per ROUND cycle, no stalls; in_valid ignored outside IDLE.
REQ-022 SubBytes SHALL use 16 instances of the team sbox module (ports a, c); MixColumns in GF(2^8), polynomial 0x11B.
REQ-023 Latency: request accepted at edge T; out_valid=1 after edge T+15; 15 ROUND cycles exactly.
REQ-024 DONE: out_valid=1, ciphertext_out=state_reg held stable until out_valid&&out_ready; then IDLE.
REQ-025 in_ready SHALL be 0 in ROUND and DONE; no accept in the DONE handshake cycle; minimum request spacing 17 cycles.
REQ-026 key_out SHALL stay constant from accept until return to IDLE.
REQ-027 Outside ROUND: round_num=0, enable_round=0.
REQ-028 ciphertext_out SHALL be 0 whenever out_valid=0.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE; state_reg, key_out, counter = 0; in_ready=1 after reset release, out_valid=0, enable_round=0, round_num=0, ciphertext_out=0.
REQ-030 Reset asserted mid-ROUND or in DONE SHALL abort; no out_valid for the aborted block, ever.
REQ-031 First accept SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-032 FIPS-197 C.3: key 000102..1f, plaintext 00112233445566778899aabbccddeeff -> ciphertext 8ea2b7ca516745bfeafc49904b496089, out_valid exactly 15 cycles after accept edge.
REQ-033 Same vector: state_reg after counter-0 cycle = 00102030405060708090a0b0c0d0e0f0; round_num sequence 0..14; enable_round 1 for 14 cycles then 0.
REQ-034 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and ciphertext held, in_ready=0 throughout; in_valid pulses ignored.
REQ-035 Back-to-back: in_valid held high with two vectors -> second accepted exactly 1 cycle after first output handshake; both ciphertexts correct.
REQ-036 reset_n pulsed low at counter 7 -> all outputs zero asynchronously, no out_valid; next request yields correct C.3 result.
REQ-037 Random: 1000 random key/plaintext pairs vs software AES-256 model with random out_ready -> all match, no drops or duplicates.

Source files
------------

// File: rtl/aes_round_core.sv
// AES-256 iterative encryption core: one round per clock, 15 round cycles per block.
// Round keys come combinationally from an external key expansion driven by key_out/round_num.

module sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);
  // GF(2^8) multiply, reduction polynomial 0x11B
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = x;
    bb = y;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  logic [7:0] inv;

  // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform
  always_comb begin
    inv = a;
    for (int i = 0; i < 6; i++) begin
      inv = gf_mul(gf_mul(inv, inv), a);
    end
    inv = gf_mul(inv, inv);
    c = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_round_core (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext_in,
  input  logic [255:0] key_in,
  output logic [255:0] key_out,
  output logic [3:0]   round_num,
  output logic         enable_round,
  input  logic [127:0] round_key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext_out
);
  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid and data stable until then, ready never depends on valid.

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] LAST_ROUND = 4'd14;

  state_t       state;
  state_t       state_next;
  logic [3:0]   counter;
  logic [127:0] state_reg;
  logic [127:0] sub_bytes;
  logic [127:0] shift_rows;
  logic [127:0] mix_cols;
  logic [127:0] round_result;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sbox
      sbox u_sbox (
        .a (state_reg[127-8*gi -: 8]),
        .c (sub_bytes[127-8*gi -: 8])
      );
    end
  endgenerate

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns
  always_comb begin
    shift_rows = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        shift_rows[127-8*(r+4*c) -: 8] = sub_bytes[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
  end

  always_comb begin
    mix_cols = '0;
    for (int c = 0; c < 4; c++) begin
      mix_cols[127-32*c -: 32] = mix_column(shift_rows[127-32*c -: 32]);
    end
  end

  always_comb begin
    round_result = mix_cols ^ round_key_in;
    if (counter == 4'd0) begin
      round_result = state_reg ^ round_key_in;
    end else if (counter == LAST_ROUND) begin
      round_result = shift_rows ^ round_key_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      counter   <= 4'd0;
      state_reg <= '0;
      key_out   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state_reg <= plaintext_in;
            key_out   <= key_in;
            counter   <= 4'd0;
          end
        end
        ROUND: begin
          state_reg <= round_result;
          counter   <= (counter == LAST_ROUND) ? 4'd0 : counter + 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = ROUND;
      ROUND:   if (counter == LAST_ROUND) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    round_num      = 4'd0;
    enable_round   = 1'b0;
    ciphertext_out = '0;
    case (state)
      IDLE:  in_ready = 1'b1;
      ROUND: begin
        round_num    = counter;
        enable_round = (counter != LAST_ROUND);
      end
      DONE: begin
        out_valid      = 1'b1;
        ciphertext_out = state_reg;
      end
      default: begin
      end
    endcase
  end
endmodule

// File: tb/tb_aes_round_core.sv
// Bench for aes_round_core: plays the key expansion role, checks directed
// FIPS-197 vectors, backpressure, back-to-back, reset abort and random traffic.

module tb_aes_round_core;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext_in;
  logic [255:0] key_in;
  logic [255:0] key_out;
  logic [3:0]   round_num;
  logic         enable_round;
  logic [127:0] round_key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext_out;

  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C3_R0  = 128'h00102030405060708090a0b0c0d0e0f0;

  int checks = 0;
  int errors = 0;
  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  aes_round_core dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .plaintext_in   (plaintext_in),
    .key_in         (key_in),
    .key_out        (key_out),
    .round_num      (round_num),
    .enable_round   (enable_round),
    .round_key_in   (round_key_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .ciphertext_out (ciphertext_out)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Carry-less product followed by polynomial reduction modulo 0x11B
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    logic [7:0] o;
    logic [7:0] cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        o[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ cst[b];
      sbox_tab[x] = o;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  function automatic logic [127:0] key_sched(input logic [255:0] key, input int rnd);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    if (rnd < 0 || rnd > 14) return '0;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gf_mul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [255:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] rk;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int r = 0; r <= 14; r++) begin
      rk = key_sched(key, r);
      if (r > 0) begin
        for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
        for (int row = 0; row < 4; row++)
          for (int col = 0; col < 4; col++)
            s[row+4*col] = t[row+4*((col+row)%4)];
        if (r < 14) begin
          for (int col = 0; col < 4; col++) begin
            for (int j = 0; j < 4; j++) a[j] = s[4*col+j];
            for (int j = 0; j < 4; j++)
              s[4*col+j] = gf_mul(8'h02, a[j]) ^ gf_mul(8'h03, a[(j+1)%4]) ^ a[(j+2)%4] ^ a[(j+3)%4];
          end
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Key expansion stand-in: combinational round key for the requested round
  always_comb round_key_in = key_sched(key_out, int'(round_num));

  // Starts at a negedge in IDLE; ends at the negedge after out_valid rises.
  task automatic run_txn(input logic [255:0] key, input logic [127:0] pt, input logic [127:0] exp_ct,
                         input bit kat, input bit hold, input logic [255:0] nkey, input logic [127:0] npt);
    in_valid     = 1'b1;
    key_in       = key;
    plaintext_in = pt;
    out_ready    = 1'b0;
    chk("in_ready_idle", 256'(in_ready), 256'(1));
    @(posedge clk);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (hold) begin
          key_in       = nkey;
          plaintext_in = npt;
        end else begin
          in_valid = 1'b0;
        end
      end
      chk("round_num", 256'(round_num), 256'(k));
      chk("enable_round", 256'(enable_round), 256'(k < 14));
      chk("out_valid_busy", 256'(out_valid), 256'(0));
      chk("in_ready_busy", 256'(in_ready), 256'(0));
      chk("key_out_held", key_out, key);
      chk("ct_zero_busy", 256'(ciphertext_out), 256'(0));
      if (kat && k == 1) chk("state_after_r0", 256'(dut.state_reg), 256'(C3_R0));
    end
    @(negedge clk);
    chk("out_valid_lat15", 256'(out_valid), 256'(1));
    chk("ciphertext", 256'(ciphertext_out), 256'(exp_ct));
    chk("round_num_done", 256'(round_num), 256'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] bkey;
    logic [127:0] bpt;
    logic [127:0] held_ct;
    int           ov_count;
    int           sent;
    int           got;
    int           zero_viol;
    bit           took;

    reset_n      = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    key_in       = '0;
    plaintext_in = '0;

    init_sbox();
    chk("model_sbox_00", 256'(sbox_tab[8'h00]), 256'(8'h63));
    chk("model_sbox_53", 256'(sbox_tab[8'h53]), 256'(8'hed));
    chk("model_c3", 256'(aes_ref(C3_KEY, C3_PT)), 256'(C3_CT));

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_enable", 256'(enable_round), 256'(0));
    chk("rst_round_num", 256'(round_num), 256'(0));
    chk("rst_ct", 256'(ciphertext_out), 256'(0));
    chk("rst_key_out", key_out, 256'(0));

    // First accept on the first rising edge after release, C.3 vector
    reset_n = 1'b1;
    run_txn(C3_KEY, C3_PT, C3_CT, 1'b1, 1'b0, '0, '0);

    // Backpressure in DONE with stray in_valid pulses
    held_ct = ciphertext_out;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      key_in   = {8{$urandom()}};
      @(negedge clk);
      chk("bp_out_valid", 256'(out_valid), 256'(1));
      chk("bp_ct_held", 256'(ciphertext_out), 256'(C3_CT));
      chk("bp_in_ready", 256'(in_ready), 256'(0));
    end
    chk("bp_ct_stable", 256'(held_ct), 256'(ciphertext_out));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs_out_valid", 256'(out_valid), 256'(0));
    chk("hs_in_ready", 256'(in_ready), 256'(1));
    chk("hs_ct_zero", 256'(ciphertext_out), 256'(0));

    // Back-to-back: in_valid stays high, second block queued behind the first
    bkey = {8{$urandom()}};
    bpt  = {4{$urandom()}};
    run_txn(C3_KEY, C3_PT, C3_CT, 1'b0, 1'b1, bkey, bpt);
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_out_valid", 256'(out_valid), 256'(0));
    chk("b2b_in_ready", 256'(in_ready), 256'(1));
    run_txn(bkey, bpt, aes_ref(bkey, bpt), 1'b0, 1'b0, '0, '0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_done", 256'(out_valid), 256'(0));
    out_ready = 1'b0;

    // Asynchronous reset at round 7 aborts the block
    in_valid     = 1'b1;
    key_in       = C3_KEY;
    plaintext_in = C3_PT;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_round7", 256'(round_num), 256'(7));
    #2 reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 256'(out_valid), 256'(0));
    chk("abort_ct", 256'(ciphertext_out), 256'(0));
    chk("abort_round_num", 256'(round_num), 256'(0));
    chk("abort_enable", 256'(enable_round), 256'(0));
    chk("abort_key_out", key_out, 256'(0));
    chk("abort_state", 256'(dut.state_reg), 256'(0));
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    ov_count = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) ov_count++;
    end
    chk("abort_no_out_valid", 256'(ov_count), 256'(0));
    run_txn(C3_KEY, C3_PT, C3_CT, 1'b1, 1'b0, '0, '0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_abort_idle", 256'(in_ready), 256'(1));

    // Random traffic with random out_ready
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sent      = 0;
    got       = 0;
    zero_viol = 0;
    took      = 1'b0;
    for (int cyc = 0; cyc < 60000 && got < 1000; cyc++) begin
      @(negedge clk);
      if (!out_valid && ciphertext_out != '0) zero_viol++;
      if (took) begin
        in_valid = 1'b0;
        took     = 1'b0;
      end
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        key_in       = {8{$urandom()}};
        plaintext_in = {4{$urandom()}};
        in_valid     = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(aes_ref(key_in, plaintext_in));
        sent++;
        took = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rand_duplicate", 256'(exp_q.size()), 256'(1));
        else chk("rand_ct", 256'(ciphertext_out), 256'(exp_q.pop_front()));
        got++;
      end
    end
    in_valid = 1'b0;
    chk("rand_all_received", 256'(got), 256'(1000));
    chk("rand_sent_eq_got", 256'(sent), 256'(got));
    chk("rand_queue_empty", 256'(exp_q.size()), 256'(0));
    chk("rand_ct_zero_idle", 256'(zero_viol), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
